// File: rtl/serial_add_sched.sv
// Nibble-serial adder scheduler: two round-robin requesters share one external
// 4-bit adder slice, with the carry registered between nibbles (LSB first).
module serial_add_sched #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_sum,
  input  logic             slice_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned IW  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             id_reg;
  logic             last_grant;

  logic             gnt_id;
  logic             take;
  logic             last_nib;
  logic [IW-1:0]    base;

  // Grant selection, handshakes and slice/response drive
  always_comb begin
    gnt_id = req1_valid;
    if (req0_valid && req1_valid) gnt_id = ~last_grant;
    req0_ready = rst_n && (state == IDLE) && req0_valid && !gnt_id;
    req1_ready = rst_n && (state == IDLE) && req1_valid && gnt_id;
    take       = req0_ready || req1_ready;
    last_nib   = (cnt == CW'(NIB - 1));
    base       = IW'(cnt) << 2;

    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    if (state == RUN) begin
      slice_a   = a_reg[base +: 4];
      slice_b   = b_reg[base +: 4];
      slice_cin = carry_reg;
    end

    rsp_valid = (state == RESP);
    rsp_id    = (state == RESP) ? id_reg : 1'b0;
    rsp_sum   = (state == RESP) ? sum_reg : '0;
    rsp_cout  = (state == RESP) ? carry_reg : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
      carry_reg  <= 1'b0;
      id_reg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            a_reg      <= gnt_id ? req1_a : req0_a;
            b_reg      <= gnt_id ? req1_b : req0_b;
            carry_reg  <= gnt_id ? req1_cin : req0_cin;
            id_reg     <= gnt_id;
            last_grant <= gnt_id;
            cnt        <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_reg[base +: 4] <= slice_sum;
          carry_reg          <= slice_cout;
          cnt                <= cnt + 1'b1;
          if (last_nib) state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sched.sv
// Bench for serial_add_sched: transaction-level model checked every cycle plus
// directed vectors with literal expected results.
module tb_serial_add_sched;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_cin, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_cin, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic [3:0]   slice_a, slice_b, slice_sum;
  logic         slice_cin, slice_cout;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [W-1:0] rsp_sum;

  int tests = 0;
  int fails = 0;

  serial_add_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_ready(req1_ready),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_sum(slice_sum), .slice_cout(slice_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit adder slice
  assign {slice_cout, slice_sum} = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase tracked as idle / running nibble k / holding a response
  logic         m_run, m_resp, m_last, m_id, m_cin;
  int           m_k;
  logic [W-1:0] m_a, m_b;
  logic [W:0]   m_res;
  int           n_acc = 0;
  int           n_rsp = 0;

  initial begin : model
    logic e_idle, e_r0, e_r1;
    longint unsigned sh, mask, e_sa, e_sb, e_sc;
    m_run = 0; m_resp = 0; m_last = 1; m_id = 0; m_k = 0;
    m_a = '0; m_b = '0; m_cin = 0; m_res = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_run = 0; m_resp = 0; m_last = 1; m_k = 0;
        n_rsp = n_acc;
      end
      e_idle = rst_n && !m_run && !m_resp;
      e_r0 = e_idle && req0_valid && (!req1_valid || m_last);
      e_r1 = e_idle && req1_valid && (!req0_valid || !m_last);
      e_sa = 0; e_sb = 0; e_sc = 0;
      if (m_run) begin
        sh   = 64'(4 * m_k);
        mask = (64'(1) << sh) - 1;
        e_sa = (64'(m_a) >> sh) & 64'hF;
        e_sb = (64'(m_b) >> sh) & 64'hF;
        e_sc = (((64'(m_a) & mask) + (64'(m_b) & mask) + 64'(m_cin)) >> sh) & 64'h1;
      end
      check("req0_ready", 64'(req0_ready), 64'(e_r0));
      check("req1_ready", 64'(req1_ready), 64'(e_r1));
      check("slice_a", 64'(slice_a), e_sa);
      check("slice_b", 64'(slice_b), e_sb);
      check("slice_cin", 64'(slice_cin), e_sc);
      check("rsp_valid", 64'(rsp_valid), 64'(m_resp));
      check("rsp_sum", 64'(rsp_sum), m_resp ? 64'(m_res[W-1:0]) : 64'd0);
      check("rsp_cout", 64'(rsp_cout), m_resp ? 64'(m_res[W]) : 64'd0);
      check("rsp_id", 64'(rsp_id), m_resp ? 64'(m_id) : 64'd0);
      if (rst_n) begin
        if (e_r0 || e_r1) begin
          m_id   = e_r1;
          m_last = e_r1;
          m_a    = e_r1 ? req1_a : req0_a;
          m_b    = e_r1 ? req1_b : req0_b;
          m_cin  = e_r1 ? req1_cin : req0_cin;
          m_res  = (W+1)'(m_a) + (W+1)'(m_b) + (W+1)'(m_cin);
          m_run  = 1; m_k = 0;
          n_acc++;
        end else if (m_run) begin
          m_k++;
          if (m_k == NIB) begin m_run = 0; m_resp = 1; end
        end else if (m_resp && rsp_ready) begin
          m_resp = 0;
          n_rsp++;
        end
      end
    end
  end

  // Issue one request, wait for grant, then return the edge count until rsp_valid
  task automatic do_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, output int lat);
    bit ok = 0;
    if (id) begin req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1; end
    else    begin req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1; end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = n; break; end
    end
  endtask

  initial begin : stim
    int lat, r0c, r1c, nr;
    logic [W-1:0] hold_sum;
    logic         hold_cout, hold_id;
    rst_n = 0; rsp_ready = 1;
    req0_valid = 1; req0_a = '0; req0_b = '0; req0_cin = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0;
    #2;
    check("reset_ready0", 64'(req0_ready), 0);
    check("reset_rsp_valid", 64'(rsp_valid), 0);
    check("reset_slice_a", 64'(slice_a), 0);
    req0_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Single operations
    do_req(0, 16'h1234, 16'h4321, 0, lat);
    check("lat_1234", 64'(lat), NIB);
    check("sum_1234", 64'(rsp_sum), 64'h5555);
    check("cout_1234", 64'(rsp_cout), 0);
    check("id_1234", 64'(rsp_id), 0);
    @(posedge clk); #1;
    do_req(1, 16'hFFFF, 16'h0001, 0, lat);
    check("sum_ffff", 64'(rsp_sum), 64'h0000);
    check("cout_ffff", 64'(rsp_cout), 1);
    check("id_ffff", 64'(rsp_id), 1);
    @(posedge clk); #1;
    do_req(0, 16'h0000, 16'h0000, 1, lat);
    check("sum_cin", 64'(rsp_sum), 64'h0001);
    check("cout_cin", 64'(rsp_cout), 0);
    @(posedge clk); #1;

    // Arbitration from reset with both requesters always valid
    rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 0;
    req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1;
    req0_valid = 1; req1_valid = 1;
    r0c = 0; r1c = 0; nr = 0;
    for (int i = 0; i < 200 && nr < 4; i++) begin
      @(negedge clk);
      if (req0_ready) r0c++;
      if (req1_ready) r1c++;
      if (rsp_valid && rsp_ready) begin
        check("arb_id", 64'(rsp_id), 64'(nr % 2));
        check("arb_sum", 64'(rsp_sum), (nr % 2) ? 64'h0001 : 64'h3333);
        check("arb_cout", 64'(rsp_cout), (nr % 2) ? 64'd1 : 64'd0);
        nr++;
      end
    end
    check("arb_responses", 64'(nr), 4);
    check("arb_ready0_pulses", 64'(r0c), 2);
    check("arb_ready1_pulses", 64'(r1c), 2);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (8) @(posedge clk);
    #1;

    // Backpressure on the response port
    rsp_ready = 0;
    do_req(0, 16'h0F0F, 16'h00F1, 0, lat);
    check("bp_sum", 64'(rsp_sum), 64'h1000);
    hold_sum = rsp_sum; hold_cout = rsp_cout; hold_id = rsp_id;
    @(posedge clk); #1 req1_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(rsp_valid), 1);
      check("bp_hold", 64'({hold_id, hold_cout, hold_sum}), 64'({rsp_id, rsp_cout, rsp_sum}));
      check("bp_ready1", 64'(req1_ready), 0);
      if (i < 2) @(posedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(negedge clk);
    check("bp_still_resp", 64'(rsp_valid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_left_resp", 64'(rsp_valid), 0);
    check("bp_idle_grant", 64'(req1_ready), 1);
    @(posedge clk); #1 req1_valid = 0;
    repeat (10) @(posedge clk);
    #1;

    // Asynchronous reset during the second RUN cycle
    req0_a = 16'h1111; req0_b = 16'h0001; req0_cin = 0; req0_valid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req0_ready) break;
    end
    @(posedge clk); #1 req0_valid = 0;
    @(posedge clk); #1 rst_n = 0;
    #1;
    check("rst_slice_a", 64'(slice_a), 0);
    check("rst_slice_cin", 64'(slice_cin), 0);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_rsp_sum", 64'(rsp_sum), 0);
    @(posedge clk); #1 rst_n = 1;
    do_req(0, 16'h00FF, 16'h0001, 0, lat);
    check("post_rst_lat", 64'(lat), NIB);
    check("post_rst_sum", 64'(rsp_sum), 64'h0100);
    check("post_rst_cout", 64'(rsp_cout), 0);
    @(posedge clk); #1;

    // Random regression against the model
    for (int i = 0; i < 1000; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom_range(0, 1));
      req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (20) @(posedge clk);
    #1;
    check("no_loss_or_dup", 64'(n_rsp), 64'(n_acc));
    check("rand_activity", 64'(n_acc > 100), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
